// File: rtl/sarray_mem_resp_pkg.sv
// Shared widths and types for the line-array read/write responder.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 64
`endif
`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 32
`endif

package sarray_mem_resp_pkg;

    localparam int ADDR_W  = `ADDR_WIDTH;
    localparam int LOAD_W  = `SARRAY_LOAD_WIDTH;
    localparam int STORE_W = `SARRAY_STORE_WIDTH;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [LOAD_W-1:0]  line_t;
    typedef logic [STORE_W-1:0] store_t;

    function automatic addr_t line_of(addr_t addr, int shift);
        return addr >> shift;
    endfunction

endpackage

// File: rtl/sarray_resp_fifo.sv
// Circular response queue; head entry is presented combinationally.
module sarray_resp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sarray_mem_resp.sv
// Line-addressed storage array: AR/R read channel through a response
// queue, fire-and-forget AW writes into the low bits of a line.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 64
`endif
`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 32
`endif

module sarray_mem_resp
    import sarray_mem_resp_pkg::*;
#(
    parameter int MEM_DEPTH  = 64,
    parameter int LINE_SHIFT = 8,
    parameter int RESP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sarray_ar_valid_i,
    output logic                           sarray_ar_ready_o,
    input  logic [`ADDR_WIDTH-1:0]         sarray_ar_addr_i,
    output logic                           sarray_r_valid_o,
    input  logic                           sarray_r_ready_i,
    output logic [`SARRAY_LOAD_WIDTH-1:0]  sarray_r_data_o,
    input  logic                           sarray_aw_valid_i,
    output logic                           sarray_aw_ready_o,
    input  logic [`ADDR_WIDTH-1:0]         sarray_aw_addr_i,
    input  logic [`SARRAY_STORE_WIDTH-1:0] sarray_aw_data_i,
    output logic                           err_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    line_t            mem [MEM_DEPTH];
    addr_t            ar_line;
    addr_t            aw_line;
    logic [IDX_W-1:0] ar_idx;
    logic [IDX_W-1:0] aw_idx;
    logic             ar_ok;
    logic             aw_ok;
    logic             ar_fire;
    logic             aw_fire;
    logic             r_pop;
    logic             rd_pend;
    line_t            rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occ;
    logic [CNT_W:0]   limit;

    assign ar_line = line_of(sarray_ar_addr_i, LINE_SHIFT);
    assign aw_line = line_of(sarray_aw_addr_i, LINE_SHIFT);
    assign ar_ok   = ar_line < addr_t'(MEM_DEPTH);
    assign aw_ok   = aw_line < addr_t'(MEM_DEPTH);
    assign ar_idx  = ar_line[IDX_W-1:0];
    assign aw_idx  = aw_line[IDX_W-1:0];

    assign sarray_aw_ready_o = 1'b1;
    assign aw_fire = sarray_aw_valid_i;
    assign ar_fire = sarray_ar_valid_i & sarray_ar_ready_o;
    assign r_pop   = sarray_r_valid_o & sarray_r_ready_i;

    // A slot being drained this cycle may be reclaimed by a new request.
    assign occ   = {1'b0, fifo_count} + (CNT_W + 1)'(rd_pend);
    assign limit = (CNT_W + 1)'(RESP_DEPTH) + (CNT_W + 1)'(r_pop);
    assign sarray_ar_ready_o = occ < limit;

    // Non-blocking read sees pre-write data on a same-line collision.
    always_ff @(posedge clk) begin
        if (aw_fire && aw_ok) mem[aw_idx][STORE_W-1:0] <= sarray_aw_data_i;
        if (ar_fire) rd_data <= ar_ok ? mem[ar_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            rd_pend <= ar_fire;
            if ((ar_fire && !ar_ok) || (aw_fire && !aw_ok)) err_o <= 1'b1;
        end
    end

    sarray_resp_fifo #(
        .WIDTH (LOAD_W),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (rd_data),
        .pop       (r_pop),
        .pop_data  (sarray_r_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign sarray_r_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_sarray_mem_resp.sv
// Scoreboard bench for sarray_mem_resp: directed reads/writes, stalls,
// collisions, out-of-range accesses and mid-flight reset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 64
`endif
`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 32
`endif

module tb_sarray_mem_resp;

    localparam logic [63:0] LO  = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [31:0] aw_data;
    logic        err;

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int          resp_t [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_resp = 0;
    int          cyc = 0;
    int          t0;
    int          n0;
    int          acc;
    logic [63:0] d0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_data;

    sarray_mem_resp dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sarray_ar_valid_i (ar_valid),
        .sarray_ar_ready_o (ar_ready),
        .sarray_ar_addr_i  (ar_addr),
        .sarray_r_valid_o  (r_valid),
        .sarray_r_ready_i  (r_ready),
        .sarray_r_data_o   (r_data),
        .sarray_aw_valid_i (aw_valid),
        .sarray_aw_ready_o (aw_ready),
        .sarray_aw_addr_i  (aw_addr),
        .sarray_aw_data_i  (aw_data),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every R handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && r_valid) chk("r_data_hold", r_data, prev_data);
            if (r_valid && r_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got %h expected none", r_data);
                end else begin
                    e = sb.pop_front();
                    chk("r_data", r_data & e.mask, e.data & e.mask);
                    n_resp++;
                    resp_t.push_back(cyc);
                end
            end
            prev_hold = r_valid && !r_ready;
            prev_data = r_data;
        end
    end

    task automatic ar_send(input logic [31:0] a, input logic [63:0] d,
                           input logic [63:0] m);
        ar_valid = 1'b1;
        ar_addr  = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ar_ready) begin
                sb.push_back('{d, m});
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ar_timeout: got no ar_ready expected accept addr %h", a);
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [31:0] d);
        aw_valid = 1'b1;
        aw_addr  = a;
        aw_data  = d;
        @(posedge clk);
        #1;
        aw_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !r_valid) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    endtask

    task automatic stall_step();
        @(negedge clk);
        if (ar_ready && acc < 6) begin
            sb.push_back('{64'hC0DE_0000 | 64'(8 + acc), LO});
            acc++;
        end
        @(posedge clk);
        #1;
        ar_addr = 32'(8 + acc) << 8;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ar_valid = 1'b0;
        ar_addr  = '0;
        r_ready  = 1'b1;
        aw_valid = 1'b0;
        aw_addr  = '0;
        aw_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write then read inside the same line, with latency check
        aw_send(32'h100, 32'hA5);
        ar_send(32'h1FF, 64'hA5, LO);
        ar_valid = 1'b0;
        chk("lat_n1_valid", r_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", r_valid, 1);
        chk("basic_err", err, 0);
        wait_drain();

        // Back-to-back streaming over every line
        for (int i = 0; i < 64; i++) aw_send(32'(i) << 8, 32'hC0DE_0000 | 32'(i));
        resp_t.delete();
        t0 = cyc;
        for (int i = 0; i < 64; i++)
            ar_send(32'(i) << 8, 64'hC0DE_0000 | 64'(i), LO);
        ar_valid = 1'b0;
        chk("b2b_issue_cycles", 64'(cyc - t0), 64);
        wait_drain();
        chk("b2b_resp_count", 64'(resp_t.size()), 64);
        if (resp_t.size() == 64)
            chk("b2b_resp_span", 64'(resp_t[63] - resp_t[0]), 63);

        // Backpressure: six requests against a four-deep queue
        r_ready  = 1'b0;
        acc      = 0;
        n0       = n_resp;
        ar_valid = 1'b1;
        ar_addr  = 32'h800;
        repeat (8) stall_step();
        chk("stall_accepted", 64'(acc), 4);
        chk("stall_ar_ready", ar_ready, 0);
        chk("stall_r_valid", r_valid, 1);
        d0 = r_data;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("stall_data_stable", r_data, d0);
        chk("stall_no_resp", 64'(n_resp - n0), 0);
        r_ready = 1'b1;
        for (int i = 0; i < 20 && acc < 6; i++) stall_step();
        ar_valid = 1'b0;
        chk("stall_total_acc", 64'(acc), 6);
        wait_drain();
        chk("stall_resp_count", 64'(n_resp - n0), 6);

        // Same-cycle read and write to line 3
        aw_send(32'h300, 32'h11);
        wait_drain();
        aw_valid = 1'b1;
        aw_addr  = 32'h300;
        aw_data  = 32'h22;
        ar_send(32'h300, 64'h11, LO);
        aw_valid = 1'b0;
        ar_send(32'h300, 64'h22, LO);
        ar_valid = 1'b0;
        wait_drain();

        // Out-of-range read and write
        chk("oor_err_before", err, 0);
        ar_send(32'h4000, 64'h0, ALL);
        ar_valid = 1'b0;
        chk("oor_err_next", err, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("oor_err_sticky", err, 1);
        aw_send(32'h4000, 32'hDEAD_BEEF);
        ar_send(32'h0, 64'hC0DE_0000, LO);
        ar_send(32'h3F00, 64'hC0DE_003F, LO);
        ar_valid = 1'b0;
        wait_drain();

        // Reset with responses queued
        r_ready = 1'b0;
        ar_send(32'h100, 64'hC0DE_0001, LO);
        ar_send(32'h200, 64'hC0DE_0002, LO);
        ar_send(32'h400, 64'hC0DE_0004, LO);
        ar_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rq_r_valid", r_valid, 1);
        n0    = n_resp;
        rst_n = 1'b0;
        #1;
        chk("rq_rst_r_valid", r_valid, 0);
        chk("rq_rst_ar_ready", ar_ready, 1);
        chk("rq_rst_err", err, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        r_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("rq_no_stale", 64'(n_resp - n0), 0);
        chk("rq_idle_valid", r_valid, 0);
        ar_send(32'h200, 64'hC0DE_0002, LO);
        ar_valid = 1'b0;
        wait_drain();
        chk("rq_post_resp", 64'(n_resp - n0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
